envelope_vca: RTL and testbench
===============================

// Module: envelope_vca
// PURPOSE
//  Amplitude stage directly downstream of the ADSR envelope generator: scales a signed
//  oscillator sample stream by the generator's 8-bit level (out_value/busy).
//  Gain changes are deferred to sample zero-crossings (with timeout) to avoid clicks.
//  2-stage valid/ready pipeline; feeds the voice mixer.
// PARAMETERS
//  SAMPLE_W    16  width of signed input/output samples
//  ZC_TIMEOUT  64  max accepted samples without a gain update before one is forced (>=1)
// PORTS
//  clk           in   1         system clock, all logic on posedge
//  rst_b         in   1         asynchronous active-low reset
//  sample_in     in   SAMPLE_W  signed oscillator sample
//  sample_valid  in   1         sample_in valid
//  sample_ready  out  1         stage can accept sample_in this cycle
//  env_value     in   8         envelope level (envelope_generator out_value), unsigned
//  env_busy      in   1         envelope active (envelope_generator busy)
//  sample_out    out  SAMPLE_W  signed scaled sample
//  out_valid     out  1         sample_out valid
//  out_ready     in   1         downstream accepts sample_out
//  active        out  1         env_busy | (gain_reg!=0) | any pipeline stage valid
// BEHAVIOUR
//  Reset (async): FSM=MUTED, gain_reg=0, prev_sample=0, zc_cnt=0, s1/s2 valid=0,
//   sample_out=0, out_valid=0, active=0; sample_ready forced 0 while rst_b low.
//  Accept = sample_valid & sample_ready. Stage1 captures sample and gain_used on accept;
//   stage2 registers product. Advance rule per stage: load when empty or next stage loads.
//   sample_ready = rst_b & (!s1_v | !s2_v | out_ready). No bubbles: full throughput
//   with out_ready=1; latency 2 cycles accept->out_valid. Stall holds sample_out stable.
//  Update event (evaluated only on accept): zc | timeout, where
//   zc = (sample_in==0) | (sign(sample_in)!=sign(prev_sample)); timeout = (zc_cnt==ZC_TIMEOUT-1).
//   On accept: prev_sample<=sample_in; zc_cnt<=event?0:zc_cnt+1. No accept -> nothing changes.
//  Target: env_busy ? env_value : 0. On event gain_reg<=target;
//   gain_used = event ? target : gain_reg (new gain applies to the triggering sample).
//  FSM (transitions on clock edge; gain writes only on events):
//   MUTED:    gain_reg==0. env_busy -> TRACKING.
//   TRACKING: events load env_value. !env_busy -> FADING.
//   FADING:   env_busy -> TRACKING (event same cycle loads env_value);
//             else event -> gain_reg<=0, -> MUTED.
//   env_busy transitions between accepts act on the next accept only.
//  Arithmetic: prod = $signed(sample) * $signed({1'b0,gain_used}) (SAMPLE_W+9 bits);
//   sample_out = prod >>> 8, truncated to SAMPLE_W (floor, never overflows since gain<=255).
//   gain 0 -> exactly 0; gain 255 is just below unity.
//  Reset mid-stream: pipeline contents discarded, no partial output; gain restarts at 0.
//  env_value changing while gain_reg holds is ignored until the next event.
// TESTING
//  1 rst_b low mid-stream with s1/s2 full -> out_valid=0, sample_ready=0, active=0 same
//    cycle; after release first output comes only from new accepts.
//  2 env_busy=1,env_value=128; samples 1000,-1000 (zc) -> outputs ?,-500; then 1000 -> 500;
//    latency 2 with out_ready=1.
//  3 gain 255, sample 32767 -> 32639; gain 1, sample -1 -> -1; gain 0, any sample -> 0.
//  4 ZC_TIMEOUT=64, constant sample 100, env_value 0->200 -> gain changes on exactly the
//    64th accept after last event; sample_out 0 before, 78 from that sample on.
//  5 out_ready=0 for 5 cycles with continuous valid -> 2 samples held, sample_ready=0,
//    sample_out stable; release -> no loss/dup, order preserved.
//  6 env_busy falls while gain=128, alternate +/-500 -> FADING, next accept zeroes
//    output, FSM=MUTED, active=0 once pipeline drains.

Source files
------------

// File: rtl/envelope_vca.sv
`default_nettype none
// ============================================================================
// Module   : envelope_vca
// Purpose  : Amplitude stage placed after the ADSR envelope generator. It
//            multiplies a signed oscillator sample stream by an unsigned 8-bit
//            envelope level. To avoid audible clicks, a new gain is taken up
//            only when the sample crosses zero. If no crossing happens within
//            ZC_TIMEOUT accepted samples, the update is forced anyway.
//            The datapath is a two-stage valid/ready pipeline that drives the
//            voice mixer.
// Ports    : clk          - system clock (posedge)
//            rst_b        - asynchronous active-low reset
//            sample_in    - signed oscillator sample (SAMPLE_W bits)
//            sample_valid - sample_in valid
//            sample_ready - stage can accept sample_in this cycle
//            env_value    - unsigned envelope level (8 bits)
//            env_busy     - envelope active
//            sample_out   - signed scaled sample (SAMPLE_W bits)
//            out_valid    - sample_out valid
//            out_ready    - downstream accepts sample_out
//            active       - voice still producing/holding sound
// Revision : 1.0 - initial release
// ============================================================================
module envelope_vca #(
  parameter int SAMPLE_W   = 16,
  parameter int ZC_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [7:0]          env_value,
  input  logic                env_busy,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                active
);

  localparam int                CNT_W    = (ZC_TIMEOUT > 1) ? $clog2(ZC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ZC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_MUTED    = 2'd0,
    ST_TRACKING = 2'd1,
    ST_FADING   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          gain_q, gain_d;
  logic [SAMPLE_W-1:0] prev_q;
  logic [CNT_W-1:0]    zc_cnt_q;

  logic                s1_v_q;
  logic [SAMPLE_W-1:0] s1_sample_q;
  logic [7:0]          s1_gain_q;
  logic                s2_v_q;
  logic [SAMPLE_W-1:0] s2_out_q;

  logic                s2_load;
  logic                s1_load;
  logic                accept;
  logic                zc;
  logic                timeout;
  logic                upd;
  logic [7:0]          target;
  logic [7:0]          gain_used;

  logic signed [SAMPLE_W+8:0] prod;
  logic [SAMPLE_W-1:0]        prod_sh;
  logic                       unused_prod_bits;

  // Each stage loads when it is empty or when the stage after it loads.
  // This gives full throughput without bubbles.
  assign s2_load      = !s2_v_q || out_ready;
  assign s1_load      = !s1_v_q || s2_load;
  assign sample_ready = rst_b && (!s1_v_q || !s2_v_q || out_ready);
  assign accept       = sample_valid && sample_ready;

  // A sample counts as a zero crossing when it is exactly zero or its sign
  // differs from the previous accepted sample.
  assign zc      = (sample_in == '0) || (sample_in[SAMPLE_W-1] != prev_q[SAMPLE_W-1]);
  assign timeout = (zc_cnt_q == CNT_LAST);
  assign upd     = accept && (zc || timeout);

  assign target    = env_busy ? env_value : 8'd0;
  // The sample that triggers an update already uses the new gain.
  assign gain_used = upd ? target : gain_q;

  // Gain state machine. Once the envelope has released, FADING keeps the old
  // gain until the next update event, which writes zero.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (upd) begin
      gain_d = target;
    end
    case (state_q)
      ST_MUTED: begin
        if (env_busy) state_d = ST_TRACKING;
      end
      ST_TRACKING: begin
        if (!env_busy) state_d = ST_FADING;
      end
      ST_FADING: begin
        if (env_busy)  state_d = ST_TRACKING;
        else if (upd)  state_d = ST_MUTED;
      end
      default: state_d = ST_MUTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_MUTED;
      gain_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev_q   <= '0;
      zc_cnt_q <= '0;
    end else if (accept) begin
      prev_q   <= sample_in;
      zc_cnt_q <= (zc || timeout) ? '0 : zc_cnt_q + CNT_W'(1);
    end
  end

  // Both operands are widened to the full product width, so the multiply is
  // signed with no truncation. The gain is treated as unsigned by a zero MSB.
  assign prod = $signed({{9{s1_sample_q[SAMPLE_W-1]}}, s1_sample_q}) *
                $signed({{SAMPLE_W{1'b0}}, 1'b0, s1_gain_q});
  // An arithmetic shift right by 8 is a floor divide by 256. Because
  // gain <= 255, the result always fits in SAMPLE_W bits.
  assign prod_sh          = prod[SAMPLE_W+7:8];
  assign unused_prod_bits = ^{prod[SAMPLE_W+8], prod[7:0]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_v_q      <= 1'b0;
      s1_sample_q <= '0;
      s1_gain_q   <= 8'd0;
      s2_v_q      <= 1'b0;
      s2_out_q    <= '0;
    end else begin
      if (s1_load) begin
        s1_v_q <= accept;
        if (accept) begin
          s1_sample_q <= sample_in;
          s1_gain_q   <= gain_used;
        end
      end
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_out_q <= prod_sh;
      end
    end
  end

  assign sample_out = s2_out_q;
  assign out_valid  = s2_v_q;
  // Gated by reset so the voice reports idle immediately, even if env_busy is high.
  assign active     = rst_b && (env_busy || (gain_q != 8'd0) || s1_v_q || s2_v_q);

endmodule
`default_nettype wire

// File: tb/tb_envelope_vca.sv
`default_nettype none
// ============================================================================
// Module   : tb_envelope_vca
// Purpose  : Directed self-checking bench for envelope_vca. Each expected
//            value is worked out by hand from the scaling rule
//            out = floor(sample * gain / 256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_envelope_vca;

  logic        clk;
  logic        rst_b;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  env_value;
  logic        env_busy;
  logic signed [15:0] sample_out;
  logic        out_valid;
  logic        out_ready;
  logic        active;

  int n_checks;
  int n_pass;
  int q[$];
  int zeros;

  envelope_vca #(.SAMPLE_W(16), .ZC_TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .env_value    (env_value),
    .env_busy     (env_busy),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake. Values are read before the edge updates them.
  always @(posedge clk) begin
    if (rst_b && out_valid && out_ready) q.push_back(int'(sample_out));
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Assumes inputs were set at a negedge. Waits (bounded) for the handshake edge.
  task automatic wait_accept(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (sample_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic send(input int s);
    @(negedge clk);
    sample_in    = 16'(s);
    sample_valid = 1'b1;
    wait_accept("send");
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_b        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    env_value    = 8'd0;
    env_busy     = 1'b0;
    out_ready    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ready", int'(sample_ready), 0);
    check("rst_active", int'(active), 0);
    check("rst_sample_out", int'(sample_out), 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Gain 128 taken up on a zero crossing
    @(negedge clk);
    env_busy  = 1'b1;
    env_value = 8'd128;
    q.delete();
    send(1000);    // no crossing yet, gain still 0 -> 0
    send(-1000);   // crossing -> gain 128 -> -500
    send(1000);    // crossing -> 500
    drain();
    check("t2_count", q.size(), 3);
    check("t2_first", q[0], 0);
    check("t2_neg", q[1], -500);
    check("t2_pos", q[2], 500);

    // Latency: out_valid appears two cycles after the accept cycle
    q.delete();
    send(1000);
    @(negedge clk);
    check("t2_lat1_valid", int'(out_valid), 0);
    @(negedge clk);
    check("t2_lat2_valid", int'(out_valid), 1);
    check("t2_lat2_value", int'(sample_out), 500);
    drain();

    // Arithmetic corner cases
    env_value = 8'd255;
    q.delete();
    send(0);        // exact zero is a crossing -> gain 255, output 0
    send(32767);    // 32767*255/256 -> 32639
    @(negedge clk);
    env_value = 8'd1;
    send(-1);       // crossing -> gain 1 -> floor(-1/256) = -1
    @(negedge clk);
    env_value = 8'd0;
    send(5);        // crossing -> gain 0 -> 0
    send(-32768);   // crossing, gain 0 -> 0
    drain();
    check("t3_count", q.size(), 5);
    check("t3_zero_in", q[0], 0);
    check("t3_g255", q[1], 32639);
    check("t3_g1", q[2], -1);
    check("t3_g0_pos", q[3], 0);
    check("t3_g0_neg", q[4], 0);

    // Forced update after 64 accepts without a crossing
    q.delete();
    send(100);      // crossing from -32768, gain stays 0, counter cleared
    @(negedge clk);
    env_value = 8'd200;
    for (int i = 0; i < 65; i++) send(100);
    drain();
    check("t4_count", q.size(), 66);
    zeros = 0;
    for (int i = 0; i < 64; i++) if (q[i] == 0) zeros++;
    check("t4_zeros_before", zeros, 64);
    check("t4_last_zero", q[63], 0);
    check("t4_first_new", q[64], 78);
    check("t4_after_new", q[65], 78);

    // Backpressure: gain stays 200 (no crossings among positives)
    q.delete();
    @(negedge clk);
    out_ready = 1'b0;
    send(256);
    send(512);
    @(negedge clk);
    sample_in    = 16'(768);
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_stall_ready", int'(sample_ready), 0);
      check("t5_stall_valid", int'(out_valid), 1);
      check("t5_stall_out", int'(sample_out), 200);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_accept("t5");
    send(1024);
    drain();
    check("t5_count", q.size(), 4);
    check("t5_o0", q[0], 200);
    check("t5_o1", q[1], 400);
    check("t5_o2", q[2], 600);
    check("t5_o3", q[3], 800);

    // Release: envelope drops while gain is 128
    @(negedge clk);
    env_value = 8'd128;
    q.delete();
    send(-500);     // crossing -> gain 128 -> -250
    send(500);      // crossing -> 250
    @(negedge clk);
    env_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t6_fading_active", int'(active), 1);
    send(-500);     // crossing -> gain 0 -> 0, voice mutes
    drain();
    check("t6_count", q.size(), 3);
    check("t6_o0", q[0], -250);
    check("t6_o1", q[1], 250);
    check("t6_muted_out", q[2], 0);
    check("t6_idle_active", int'(active), 0);

    // Reset in the middle of the stream while both stages are full
    @(negedge clk);
    env_busy  = 1'b1;
    env_value = 8'd128;
    out_ready = 1'b0;
    send(100);
    send(-100);
    @(negedge clk);
    #1;
    check("t1_full_valid", int'(out_valid), 1);
    rst_b = 1'b0;
    #1;
    check("t1_rst_valid", int'(out_valid), 0);
    check("t1_rst_ready", int'(sample_ready), 0);
    check("t1_rst_active", int'(active), 0);
    repeat (2) @(negedge clk);
    rst_b     = 1'b1;
    out_ready = 1'b1;
    q.delete();
    drain();
    check("t1_no_stale", q.size(), 0);
    send(-100);     // crossing from reset prev=0 -> gain 128 -> -50
    drain();
    check("t1_new_count", q.size(), 1);
    check("t1_new_value", q[0], -50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
